// File: rtl/load_align_unit.sv
// Load alignment unit: issues one word-aligned memory read per load and returns
// the addressed byte/halfword/word sign- or zero-extended, or a fault.
module load_align_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loadReq,
    input  logic [2:0]  loadSrc,
    input  logic [31:0] loadAddress,
    output logic        loadReady,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        loadValid,
    output logic [31:0] loadData,
    output logic        loadFault
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [2:0]    src_q, src_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          fault_q, fault_d;

    logic          req_legal;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ext_word;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; codes 011/110/111 are illegal.
    always_comb begin
        req_legal = 1'b0;
        case (loadSrc)
            3'b000, 3'b100: req_legal = 1'b1;
            3'b001, 3'b101: req_legal = ~loadAddress[0];
            3'b010:         req_legal = (loadAddress[1:0] == 2'b00);
            default:        req_legal = 1'b0;
        endcase
    end

    // Extraction works on the live memRdata and is only committed on the ack cycle.
    always_comb begin
        byte_sel = 8'h00;
        case (off_q)
            2'd0: byte_sel = memRdata[7:0];
            2'd1: byte_sel = memRdata[15:8];
            2'd2: byte_sel = memRdata[23:16];
            2'd3: byte_sel = memRdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = off_q[1] ? memRdata[31:16] : memRdata[15:0];
        ext_word = memRdata;
        case (src_q)
            3'b000:  ext_word = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_word = {24'h000000, byte_sel};
            3'b001:  ext_word = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_word = {16'h0000, half_sel};
            default: ext_word = memRdata;
        endcase
    end

    // Handshakes: a load is taken on a rising edge with loadReq=1 and loadReady=1;
    // memory completes on a rising edge with memReq=1 and memAck=1 (memRdata valid
    // then); loadValid is a one-cycle pulse with no back-pressure from the core.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        off_d   = off_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (loadReq) begin
                    src_d  = loadSrc;
                    off_d  = loadAddress[1:0];
                    addr_d = {loadAddress[31:2], 2'b00};
                    cnt_d  = '0;
                    if (req_legal) begin
                        state_d = WAIT;
                        fault_d = 1'b0;
                    end else begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        data_d  = 32'h0;
                    end
                end
            end
            WAIT: begin
                if (memAck) begin
                    state_d = DONE;
                    data_d  = ext_word;
                    fault_d = 1'b0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == TO_LIM) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        data_d  = 32'h0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            cnt_q   <= '0;
            data_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign loadReady = (state_q == IDLE);
    assign memReq    = (state_q == WAIT);
    assign loadValid = (state_q == DONE);
    assign memAddr   = addr_q;
    assign loadData  = data_q;
    assign loadFault = fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed loads push {fault,data} into a
// queue that a negedge monitor pops whenever loadValid is seen.
module tb_load_align_unit;

    logic        clk;
    logic        reset;
    logic        loadReq;
    logic [2:0]  loadSrc;
    logic [31:0] loadAddress;
    logic        loadReady;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic        loadValid;
    logic [31:0] loadData;
    logic        loadFault;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc[3];

    logic [32:0] exp_q[$];

    load_align_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .loadReq(loadReq), .loadSrc(loadSrc), .loadAddress(loadAddress),
        .loadReady(loadReady),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memRdata(memRdata),
        .loadValid(loadValid), .loadData(loadData), .loadFault(loadFault)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && loadValid) begin
            logic [32:0] e;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_valid: got data=0x%08h fault=%0b with nothing expected",
                         loadData, loadFault);
            end else begin
                e = exp_q.pop_front();
                if ({loadFault, loadData} !== e) begin
                    failures = failures + 1;
                    $display("FAIL result: got fault=%0b data=0x%08h expected fault=%0b data=0x%08h",
                             loadFault, loadData, e[32], e[31:0]);
                end
            end
        end
    end

    // drivers
    task automatic issue(input logic [2:0] src, input logic [31:0] addr);
        @(negedge clk);
        check("ready_before_req", {31'b0, loadReady}, 32'h1);
        loadReq     = 1'b1;
        loadSrc     = src;
        loadAddress = addr;
        @(posedge clk);
        #1 loadReq = 1'b0;
    endtask

    task automatic legal_load(input logic [2:0] src, input logic [31:0] addr,
                              input logic [31:0] rdata, input int delay,
                              input logic [31:0] exp_data);
        exp_q.push_back({1'b0, exp_data});
        issue(src, addr);
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            check("memreq_in_wait", {31'b0, memReq}, 32'h1);
            check("memaddr", memAddr, {addr[31:2], 2'b00});
            check("ready_low_wait", {31'b0, loadReady}, 32'h0);
            if (i == delay) begin
                memAck   = 1'b1;
                memRdata = rdata;
            end
            @(posedge clk);
            #1;
            memAck   = 1'b0;
            memRdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        check("valid_latency", {31'b0, loadValid}, 32'h1);
    endtask

    task automatic fault_load(input logic [2:0] src, input logic [31:0] addr);
        exp_q.push_back({1'b1, 32'h0});
        issue(src, addr);
        @(negedge clk);
        check("fault_valid_cycle1", {31'b0, loadValid}, 32'h1);
        check("fault_no_memreq", {31'b0, memReq}, 32'h0);
    endtask

    initial begin
        int n;
        int mr_cnt;
        reset       = 1'b0;
        loadReq     = 1'b0;
        loadSrc     = 3'b000;
        loadAddress = 32'h0;
        memAck      = 1'b0;
        memRdata    = 32'h0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, loadReady}, 32'h1);
        check("rst_memreq", {31'b0, memReq}, 32'h0);
        check("rst_memaddr", memAddr, 32'h0);
        check("rst_valid", {31'b0, loadValid}, 32'h0);
        check("rst_data", loadData, 32'h0);
        check("rst_fault", {31'b0, loadFault}, 32'h0);
        reset = 1'b0;

        // byte/halfword/word extraction
        legal_load(3'b000, 32'h0000_1003, 32'h80FF_1234, 1, 32'hFFFF_FF80);
        legal_load(3'b101, 32'h0000_2002, 32'hBEEF_0001, 3, 32'h0000_BEEF);
        legal_load(3'b001, 32'h0000_2002, 32'hBEEF_0001, 3, 32'hFFFF_BEEF);
        legal_load(3'b000, 32'h0000_7001, 32'h0000_7F00, 2, 32'h0000_007F);
        legal_load(3'b100, 32'h0000_7002, 32'h00FE_0000, 1, 32'h0000_00FE);
        legal_load(3'b101, 32'h0000_7000, 32'h1234_F00D, 1, 32'h0000_F00D);
        legal_load(3'b001, 32'h0000_7000, 32'h1234_7FFF, 1, 32'h0000_7FFF);
        legal_load(3'b010, 32'h0000_7004, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);

        // faults at accept
        fault_load(3'b010, 32'h0000_3001);
        fault_load(3'b001, 32'h0000_3003);
        fault_load(3'b011, 32'h0000_3000);
        fault_load(3'b101, 32'h0000_3001);

        // time-out: memReq high for exactly 4 cycles, then a faulting completion
        exp_q.push_back({1'b1, 32'h0});
        issue(3'b010, 32'h0000_4000);
        mr_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (memReq) mr_cnt++;
            else break;
        end
        check("timeout_memreq_cycles", mr_cnt, 32'd4);
        check("timeout_valid", {31'b0, loadValid}, 32'h1);
        @(posedge clk);
        #1 memAck = 1'b1;
        memRdata = 32'h5555_AAAA;
        @(posedge clk);
        #1 memAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_ack_no_valid", {31'b0, loadValid}, 32'h0);
        end

        // loadReq held high with memAck held high: one accept every 3 cycles
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 32'h0000_00C3});
        @(negedge clk);
        loadReq     = 1'b1;
        loadSrc     = 3'b100;
        loadAddress = 32'h0000_5001;
        memAck      = 1'b1;
        memRdata    = 32'hA1B2_C3D4;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (loadReady) begin
                acc[n] = cyc;
                n++;
                if (n == 3) begin
                    @(posedge clk);
                    #1 loadReq = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        check("b2b_accepts", n, 32'd3);
        check("b2b_gap0", acc[1] - acc[0], 32'd3);
        check("b2b_gap1", acc[2] - acc[1], 32'd3);
        repeat (3) @(negedge clk);
        memAck = 1'b0;

        // memAck in IDLE has no effect
        memAck   = 1'b1;
        memRdata = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_ack_no_valid", {31'b0, loadValid}, 32'h0);
            check("idle_ack_no_memreq", {31'b0, memReq}, 32'h0);
        end
        memAck = 1'b0;

        // reset mid-WAIT abandons the load asynchronously
        issue(3'b010, 32'h0000_6000);
        @(negedge clk);
        check("pre_reset_memreq", {31'b0, memReq}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_memreq", {31'b0, memReq}, 32'h0);
        check("async_rst_ready", {31'b0, loadReady}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        legal_load(3'b010, 32'h0000_0000, 32'h1357_9BDF, 2, 32'h1357_9BDF);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Load-path counterpart of the store formatting logic: accepts a load request from the core, issues one word-aligned read to data memory over a request/acknowledge handshake, then extracts the addressed byte, halfword or word with sign or zero extension. Misaligned accesses, illegal size codes and memory time-outs are reported as faults. Sits between the core's load/store stage and the data memory read port.

## Interface
- TIMEOUT, default 16: WAIT cycles without memAck before a time-out fault; 0 disables the time-out.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  reset; asynchronous, active-high.
- loadReq  input  1  request; accepted only on a rising edge where loadReady=1.
- loadSrc  input  3  funct3 size code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes are illegal.
- loadAddress  input  32  byte address of the load.
- loadReady  output  1  high in IDLE only.
- memReq  output  1  read request to memory; high in WAIT only.
- memAddr  output  32  {loadAddress[31:2], 2'b00}, registered at accept.
- memAck  input  1  memory completion; memRdata is valid in the same cycle.
- memRdata  input  32  memory read word.
- loadValid  output  1  one-cycle completion pulse.
- loadData  output  32  extended result; valid while loadValid=1, 0 on fault.
- loadFault  output  1  qualifies loadValid; 1 = misaligned, illegal or time-out.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE, loadReq=1: register loadSrc, loadAddress[1:0] and memAddr. Check legality.
  - Legal: go to WAIT and clear the time-out counter.
  - Illegal size code, lh/lhu with address[0]=1, or lw with address[1:0]≠00: go to DONE with the fault flag set. No memory access is made.
- WAIT: memReq=1.
  - memAck=1: capture memRdata and go to DONE.
  - Otherwise, with TIMEOUT≠0: increment the counter. When the counter reaches TIMEOUT without an ack, go to DONE with the fault flag set.
- DONE: loadValid=1 for exactly one cycle, then go to IDLE.
- Extraction from captured word w, offset k = address[1:0]:
  - lb/lbu: byte w[8k+7:8k].
  - lh/lhu: k=0 gives w[15:0]; k=2 gives w[31:16].
  - lw: w.
  - lb/lh: sign-extend from the top bit of the extracted field.
  - lbu/lhu: zero-extend.
- Ignored inputs:
  - loadReq while not in IDLE.
  - memAck outside WAIT.
  - memRdata when memAck=0.
- A late memAck arriving after a time-out is ignored; no second completion is produced.
- Reset at any point forces IDLE immediately; an in-flight request is abandoned.

## Timing
- Reset values:
  - loadReady=1.
  - memReq=0, memAddr=0.
  - loadValid=0, loadData=0, loadFault=0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Legal load: accept at edge 0, memReq high from cycle 1. memAck sampled at edge N (N≥1) gives loadValid in cycle N+1. Minimum latency is 2 cycles from accept to loadValid.
- Fault at accept: loadValid=1, loadFault=1 in cycle 1; memReq never rises.
- Time-out: memReq is high for exactly TIMEOUT cycles, then loadValid=1, loadFault=1 in the following cycle.
- loadReady is low from the cycle after accept through the DONE cycle. A new request is accepted at the edge ending DONE+1 at the earliest, so the back-to-back throughput is one load per 3 cycles.
- memAddr and memReq stay stable for the entire WAIT state.

## Test plan
- lb at 0x1003, memRdata=0x80FF_1234 with ack in the first WAIT cycle:
  - loadData=0xFFFF_FF80, loadFault=0.
  - loadValid arrives 2 cycles after accept.
  - memAddr=0x1000.
- lhu at 0x2002, memRdata=0xBEEF_0001, ack after 3 wait cycles:
  - loadData=0x0000_BEEF.
  - The same access as lh gives 0xFFFF_BEEF.
- lw at 0x3001, and lh at 0x3003: each gives loadFault=1 and loadData=0 in cycle 1, with memReq never asserted. loadSrc=011 gives the same result.
- TIMEOUT=4, memAck held low:
  - memReq high for exactly 4 cycles, then loadValid=1, loadFault=1.
  - memAck pulsed one cycle later produces no output.
- Handshake edge cases:
  - loadReq held high continuously: accepts occur every 3 cycles.
  - memAck pulsed while in IDLE: no effect.
- Reset asserted mid-WAIT:
  - memReq drops asynchronously and loadReady=1.
  - After reset is released, a subsequent lw at 0x0 returns the correct word.
